// File: rtl/uart_pkg.sv
// Shared UART definitions: payload width, bit timing and the
// transmit arbiter state encoding.
package uart_pkg;

    localparam int UART_DW           = 8;
    localparam int UART_CLKS_PER_BIT = 10416;
    localparam int UART_TX_TIMEOUT   = 2 * UART_CLKS_PER_BIT;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } tx_arb_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: first set request scanning upward from
// the entry after the last grant, wrapping modulo NREQ.
module rr_picker
    import uart_pkg::*;
#(
    parameter int  NREQ = 4,
    localparam int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic            o_found,
    output logic [IW-1:0]   o_idx
);

    logic [IW-1:0] cand;

    // Walk from the far end so the nearest candidate is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(i_last) + k) % NREQ);
            if (i_req[cand]) begin
                o_found = 1'b1;
                o_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NREQ
// byte streams, with message locking and stuck/abandon timeouts.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  NREQ    = 4,
    parameter int  DW      = UART_DW,
    parameter int  TIMEOUT = UART_TX_TIMEOUT,
    localparam int IW      = clog2(NREQ)
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic [NREQ-1:0]  i_req_valid,
    input  logic [NREQ*DW-1:0] i_req_data,
    input  logic [NREQ-1:0]  i_req_last,
    output logic [NREQ-1:0]  o_req_ready,
    output logic [DW-1:0]    o_tx_data,
    output logic             o_tx_start,
    input  logic             i_tx_busy,
    output logic [IW-1:0]    o_grant_id,
    output logic             o_active,
    output logic             o_err_timeout
);

    localparam int CW = clog2(TIMEOUT + 1);

    tx_arb_state_e state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_grant_q, last_grant_d;
    logic          lock_q, lock_d;
    logic          last_q, last_d;
    logic          active_q, active_d;
    logic          err_q, err_d;
    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          sel_valid;
    logic          timed_out;
    logic [DW-1:0] req_data [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_data
        assign req_data[g] = i_req_data[g*DW +: DW];
    end

    assign sel_valid = i_req_valid[grant_q];
    assign timed_out = (cnt_q >= CW'(TIMEOUT - 1));

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .i_req   (i_req_valid),
        .i_last  (last_grant_q),
        .o_found (pick_found),
        .o_idx   (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        last_d       = last_q;
        active_d     = active_q;
        err_d        = err_q;
        data_d       = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (lock_q) begin
                    if (sel_valid) begin
                        state_d = ST_LOAD;
                    end else if (timed_out) begin
                        lock_d       = 1'b0;
                        err_d        = 1'b1;
                        active_d     = 1'b0;
                        last_grant_d = grant_q;
                    end
                end else if (pick_found) begin
                    grant_d  = pick_idx;
                    active_d = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (sel_valid) begin
                    data_d  = req_data[grant_q];
                    last_d  = i_req_last[grant_q];
                    state_d = ST_START;
                end else begin
                    active_d = lock_q;
                    state_d  = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // Busy wins over a timeout reached in the same cycle.
                if (i_tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timed_out) begin
                    err_d        = 1'b1;
                    lock_d       = 1'b0;
                    active_d     = 1'b0;
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_d = ST_IDLE;
                    if (last_q) begin
                        lock_d       = 1'b0;
                        last_grant_d = grant_q;
                        active_d     = 1'b0;
                    end else begin
                        lock_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        if (state_d != state_q || (lock_q && !lock_d)) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(TIMEOUT)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(NREQ - 1);
            lock_q       <= 1'b0;
            last_q       <= 1'b0;
            active_q     <= 1'b0;
            err_q        <= 1'b0;
            data_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            last_q       <= last_d;
            active_q     <= active_d;
            err_q        <= err_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (state_q == ST_LOAD) begin
            o_req_ready[grant_q] = 1'b1;
        end
    end

    assign o_tx_start    = (state_q == ST_START);
    assign o_tx_data     = data_q;
    assign o_grant_id    = grant_q;
    assign o_active      = active_q;
    assign o_err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter against a
// queue-based round-robin message model.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int TO    = 40;
    localparam int FRAME = 6;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } byte_t;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] d;
    } ev_t;

    logic             clk;
    logic             i_reset;
    logic [NREQ-1:0]  i_req_valid;
    logic [NREQ*DW-1:0] i_req_data;
    logic [NREQ-1:0]  i_req_last;
    logic [NREQ-1:0]  o_req_ready;
    logic [DW-1:0]    o_tx_data;
    logic             o_tx_start;
    logic             i_tx_busy;
    logic [1:0]       o_grant_id;
    logic             o_active;
    logic             o_err_timeout;

    byte_t      rq [NREQ][$];
    ev_t        start_log [$];
    ev_t        exp_log [$];
    logic [1:0] acc_log [$];

    int errors;
    int checks;
    int model_last;
    int pend;
    int busy_cnt;
    bit stuck;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_req_valid   (i_req_valid),
        .i_req_data    (i_req_data),
        .i_req_last    (i_req_last),
        .o_req_ready   (o_req_ready),
        .o_tx_data     (o_tx_data),
        .o_tx_start    (o_tx_start),
        .i_tx_busy     (i_tx_busy),
        .o_grant_id    (o_grant_id),
        .o_active      (o_active),
        .o_err_timeout (o_err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic push(input int n, input logic [7:0] dat, input logic lst);
        byte_t b;
        b.d = dat;
        b.l = lst;
        rq[n].push_back(b);
    endtask

    task automatic refresh();
        for (int n = 0; n < NREQ; n++) begin
            if (rq[n].size() > 0) begin
                i_req_valid[n]         = 1'b1;
                i_req_data[n*DW +: DW] = rq[n][0].d;
                i_req_last[n]          = rq[n][0].l;
            end else begin
                i_req_valid[n]         = 1'b0;
                i_req_data[n*DW +: DW] = '0;
                i_req_last[n]          = 1'b0;
            end
        end
    endtask

    // Requesters, transmitter and logging all advance at the negedge.
    task automatic tick();
        ev_t e;
        @(negedge clk);
        if (i_reset) begin
            pend = -1;
            return;
        end
        if (pend >= 0) begin
            rq[pend].delete(0);
            pend = -1;
        end
        if (busy_cnt > 0) busy_cnt--;
        if (o_tx_start) begin
            e.id = o_grant_id;
            e.d  = o_tx_data;
            start_log.push_back(e);
            if (!stuck) busy_cnt = FRAME;
        end
        i_tx_busy = (busy_cnt > 0);
        refresh();
        for (int n = 0; n < NREQ; n++) begin
            if (o_req_ready[n] && i_req_valid[n]) begin
                pend = n;
                acc_log.push_back(2'(n));
            end
        end
    endtask

    task automatic clear_logs();
        start_log.delete();
        exp_log.delete();
        acc_log.delete();
    endtask

    // Whole messages go out in round-robin order of requester index.
    task automatic model_expect();
        byte_t mq [NREQ][$];
        byte_t b;
        ev_t   e;
        int    idx;
        bit    any;
        for (int n = 0; n < NREQ; n++) mq[n] = rq[n];
        for (int guard = 0; guard < 64; guard++) begin
            any = 1'b0;
            idx = 0;
            for (int k = NREQ; k >= 1; k--) begin
                if (mq[(model_last + k) % NREQ].size() > 0) begin
                    any = 1'b1;
                    idx = (model_last + k) % NREQ;
                end
            end
            if (!any) break;
            do begin
                b = mq[idx].pop_front();
                e.id = 2'(idx);
                e.d  = b.d;
                exp_log.push_back(e);
            end while (!b.l && mq[idx].size() > 0);
            model_last = idx;
        end
    endtask

    task automatic wait_done(input int n, input string tag);
        int c;
        c = 0;
        while (!(start_log.size() >= n && !o_active) && c < 3000) begin
            tick();
            c++;
        end
        check({tag, "_done"}, 32'(c < 3000), 1);
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, start_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < start_log.size(); i++) begin
            check($sformatf("%s_id%0d", tag, i), start_log[i].id, exp_log[i].id);
            check($sformatf("%s_d%0d", tag, i), start_log[i].d, exp_log[i].d);
        end
        for (int i = 0; i < exp_log.size() && i < acc_log.size(); i++) begin
            check($sformatf("%s_acc%0d", tag, i), acc_log[i], exp_log[i].id);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, o_req_ready, 0);
        check({tag, "_data"}, o_tx_data, 0);
        check({tag, "_start"}, o_tx_start, 0);
        check({tag, "_gid"}, o_grant_id, 0);
        check({tag, "_active"}, o_active, 0);
        check({tag, "_err"}, o_err_timeout, 0);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        tick();
        for (int n = 0; n < NREQ; n++) rq[n].delete();
        clear_logs();
        model_last = NREQ - 1;
        refresh();
        i_reset = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        bit act_bad;
        bit rdy_bad;
        ev_t e;
        logic [7:0] d;

        errors      = 0;
        checks      = 0;
        pend        = -1;
        busy_cnt    = 0;
        stuck       = 1'b0;
        model_last  = NREQ - 1;
        i_reset     = 1'b1;
        i_tx_busy   = 1'b0;
        i_req_valid = '0;
        i_req_data  = '0;
        i_req_last  = '0;
        tick();
        tick();
        check_zero("reset");
        i_reset = 1'b0;
        tick();

        // Round-robin among 0, 1, 3 with single-byte messages.
        clear_logs();
        for (int r = 0; r < 2; r++) begin
            push(0, 8'($urandom), 1'b1);
            push(1, 8'($urandom), 1'b1);
            push(3, 8'($urandom), 1'b1);
        end
        model_expect();
        refresh();
        wait_done(6, "rr");
        compare("rr");

        // Single byte with exact handshake latency.
        clear_logs();
        push(2, 8'hA5, 1'b1);
        model_last = 2;
        refresh();
        check("single_t0_ready", o_req_ready, 0);
        tick();
        check("single_t1_ready", o_req_ready, 4'b0100);
        tick();
        check("single_t2_start", o_tx_start, 1);
        check("single_t2_data", o_tx_data, 8'hA5);
        check("single_t2_ready", o_req_ready, 0);
        wait_done(1, "single");
        check("single_active", o_active, 0);
        check("single_gid", o_grant_id, 2);

        // Message lock: requester 1 holds the grant over three bytes.
        clear_logs();
        push(0, 8'($urandom), 1'b1);
        model_expect();
        refresh();
        wait_done(1, "pre_lock");
        clear_logs();
        push(1, 8'($urandom), 1'b0);
        push(1, 8'($urandom), 1'b0);
        push(1, 8'($urandom), 1'b1);
        push(0, 8'($urandom), 1'b1);
        model_expect();
        refresh();
        wait_done(4, "lock");
        compare("lock");

        // Stuck transmitter: busy never rises.
        clear_logs();
        stuck = 1'b1;
        push(1, 8'($urandom), 1'b1);
        refresh();
        n = 0;
        while (!o_tx_start && n < 200) begin
            tick();
            n++;
        end
        check("stuck_start", o_tx_start, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_err_timeout && n < 3 * TO);
        check("stuck_latency", n, TO + 1);
        check("stuck_err", o_err_timeout, 1);
        check("stuck_active", o_active, 0);
        stuck = 1'b0;
        model_last = 1;
        clear_logs();
        push(1, 8'($urandom), 1'b1);
        push(2, 8'($urandom), 1'b1);
        model_expect();
        refresh();
        wait_done(2, "stuck_next");
        compare("stuck_next");

        // Abandoned lock: requester 3 never sends its next byte.
        do_reset();
        d = 8'($urandom);
        push(3, d, 1'b0);
        e.id = 2'd3;
        e.d  = d;
        exp_log.push_back(e);
        refresh();
        n = 0;
        while (!o_tx_start && n < 200) begin
            tick();
            n++;
        end
        d = 8'($urandom);
        push(0, d, 1'b1);
        e.id = 2'd0;
        e.d  = d;
        exp_log.push_back(e);
        refresh();
        n = 0;
        while (!i_tx_busy && n < 200) begin
            tick();
            n++;
        end
        while (i_tx_busy && n < 400) begin
            tick();
            n++;
        end
        check("abandon_busy_fell", i_tx_busy, 0);
        act_bad = 1'b0;
        rdy_bad = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (!o_err_timeout) begin
                if (!o_active) act_bad = 1'b1;
                if (o_req_ready != 0) rdy_bad = 1'b1;
            end
        end while (!o_err_timeout && n < 3 * TO);
        check("abandon_latency", n, TO + 1);
        check("abandon_held_active", act_bad, 0);
        check("abandon_no_ready", rdy_bad, 0);
        check("abandon_released", o_active, 0);
        wait_done(2, "abandon");
        compare("abandon");
        check("abandon_err", o_err_timeout, 1);

        // Reset while the transmitter is mid-frame.
        do_reset();
        push(2, 8'($urandom), 1'b1);
        refresh();
        n = 0;
        while (!o_tx_start && n < 200) begin
            tick();
            n++;
        end
        tick();
        tick();
        check("rst_mid_busy", i_tx_busy, 1);
        check("rst_mid_active", o_active, 1);
        i_reset = 1'b1;
        #1;
        check_zero("rst_mid");
        do_reset();
        push(0, 8'($urandom), 1'b1);
        push(3, 8'($urandom), 1'b1);
        model_expect();
        refresh();
        wait_done(2, "post_rst");
        compare("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
